// File: rtl/dual_issue_scheduler.sv
// ---------------------------------------------------------------------------
// dual_issue_scheduler
//
// Instruction queue between fetch and decode, plus the in-order dual-issue
// decision for the execute stage.  The two oldest queue entries are shown to
// an external decoder (d0_inst/d1_inst).  The decoder returns per-slot
// register usage, and this block decides whether 0, 1 or 2 of them move into
// the X0/X1 registers this cycle.
//
// Hazard tracking is a two-stage scoreboard of pending GPR writes (X and WB).
// There is no forwarding, so any enabled source read that hits a valid tag
// stalls.  An instruction issued in cycle n is on x*_inst in n+1, its tags
// sit in WB in n+2, and a consumer can issue in n+3.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   fetch_valid/_ready     fetch pair handshake (see below)
//   fetch_data[63:0]       two instructions, [31:0] is the older one
//   flush                  drop every queued (not yet issued) instruction
//   halt                   block issue; fetch keeps filling the queue
//   d0_inst, d1_inst       queue[head], queue[head+1]; 0 if slot empty
//   dN_rd*/dN_wr*          decoder reply: source/destination GPR usage
//   dN_mem                 slot N is a load or store
//   dN_serial              slot N must issue alone into an empty pipe
//   x0/x1_valid, _inst     registered execute-stage slots (inst 0 if empty)
//   issue_count            instructions issued this cycle (0..2)
//   q_count                queue occupancy
//
// Fetch handshake: a pair transfers on any rising edge where fetch_valid and
// fetch_ready are both high.  fetch_ready depends only on reset, flush and
// the current occupancy, never on fetch_valid, and a pair that is not
// accepted is simply not written; the source holds or changes it freely.
// ---------------------------------------------------------------------------
module dual_issue_scheduler #(
  parameter int QDEPTH = 64,
  parameter int QAW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [63:0]       fetch_data,
  output logic              fetch_ready,
  input  logic              flush,
  input  logic              halt,
  output logic [31:0]       d0_inst,
  output logic [31:0]       d1_inst,
  input  logic              d0_rdA_en,
  input  logic              d0_rdB_en,
  input  logic [4:0]        d0_rdA,
  input  logic [4:0]        d0_rdB,
  input  logic              d0_wrA_en,
  input  logic              d0_wrB_en,
  input  logic [4:0]        d0_wrA,
  input  logic [4:0]        d0_wrB,
  input  logic              d0_mem,
  input  logic              d0_serial,
  input  logic              d1_rdA_en,
  input  logic              d1_rdB_en,
  input  logic [4:0]        d1_rdA,
  input  logic [4:0]        d1_rdB,
  input  logic              d1_wrA_en,
  input  logic              d1_wrB_en,
  input  logic [4:0]        d1_wrA,
  input  logic [4:0]        d1_wrB,
  input  logic              d1_mem,
  input  logic              d1_serial,
  output logic              x0_valid,
  output logic              x1_valid,
  output logic [31:0]       x0_inst,
  output logic [31:0]       x1_inst,
  output logic [1:0]        issue_count,
  output logic [QAW:0]      q_count
);

  // One pending GPR write.  Register 0 is not special here; the decoder is
  // responsible for not enabling writes/reads that do not really happen.
  typedef struct packed {
    logic       v;
    logic [4:0] r;
  } tag_t;

  // A pair fits only while at least two entries are free.
  localparam logic [QAW:0] FILL_LIMIT = (QAW+1)'(QDEPTH - 2);
  localparam logic [QAW:0] TWO_CNT    = (QAW+1)'(2);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0]    queue_q [QDEPTH];
  logic [QAW-1:0] head_q, head_d;
  logic [QAW-1:0] tail_q, tail_d;
  logic [QAW:0]   count_q, count_d;

  logic           x0_valid_q, x0_valid_d;
  logic           x1_valid_q, x1_valid_d;
  logic [31:0]    x0_inst_q, x0_inst_d;
  logic [31:0]    x1_inst_q, x1_inst_d;

  // Tag index: 0 = slot0 A, 1 = slot0 B, 2 = slot1 A, 3 = slot1 B.
  tag_t [3:0]     xtag_q, xtag_d;
  tag_t [3:0]     wbtag_q;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  // Enabled read of r collides with any valid pending write.
  function automatic logic reg_busy(input logic       en,
                                    input logic [4:0] r,
                                    input tag_t [7:0] pend);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (pend[i].v && (pend[i].r == r)) hit = 1'b1;
    end
    return en && hit;
  endfunction

  // Two enabled register references name the same GPR.
  function automatic logic same_reg(input logic       en_a,
                                    input logic [4:0] a,
                                    input logic       en_b,
                                    input logic [4:0] b);
    return en_a && en_b && (a == b);
  endfunction

  // -------------------------------------------------------------------------
  // Queue view and fetch acceptance
  // -------------------------------------------------------------------------
  logic           slot0_occ, slot1_occ;
  logic [QAW-1:0] head_p1, tail_p1;
  logic           fetch_acc;

  assign slot0_occ   = (count_q != '0);
  assign slot1_occ   = (count_q >= TWO_CNT);
  assign head_p1     = head_q + QAW'(1);
  assign tail_p1     = tail_q + QAW'(1);

  assign d0_inst     = slot0_occ ? queue_q[head_q]  : 32'h0;
  assign d1_inst     = slot1_occ ? queue_q[head_p1] : 32'h0;

  assign fetch_ready = !reset && !flush && (count_q <= FILL_LIMIT);
  assign fetch_acc   = fetch_valid && fetch_ready;

  // -------------------------------------------------------------------------
  // Issue decision
  // -------------------------------------------------------------------------
  tag_t [7:0] pend;
  logic       pend_any;
  logic       pipe_empty;
  logic       hz0, hz1;
  logic       raw01, waw01, mem01;
  logic       issue0, issue1;

  assign pend = {wbtag_q, xtag_q};

  always_comb begin
    pend_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (pend[i].v) pend_any = 1'b1;
    end
  end

  // Serializing instructions need every older instruction gone, including
  // ones that write nothing (those hold x*_valid but no tags).
  assign pipe_empty = !pend_any && !x0_valid_q && !x1_valid_q;

  assign hz0 = reg_busy(d0_rdA_en, d0_rdA, pend) ||
               reg_busy(d0_rdB_en, d0_rdB, pend);
  assign hz1 = reg_busy(d1_rdA_en, d1_rdA, pend) ||
               reg_busy(d1_rdB_en, d1_rdB, pend);

  // Slot1 cannot consume a result slot0 produces this cycle (no forwarding).
  assign raw01 = same_reg(d1_rdA_en, d1_rdA, d0_wrA_en, d0_wrA) ||
                 same_reg(d1_rdA_en, d1_rdA, d0_wrB_en, d0_wrB) ||
                 same_reg(d1_rdB_en, d1_rdB, d0_wrA_en, d0_wrA) ||
                 same_reg(d1_rdB_en, d1_rdB, d0_wrB_en, d0_wrB);

  // Two writes to one GPR in the same cycle would race in WB.
  assign waw01 = same_reg(d1_wrA_en, d1_wrA, d0_wrA_en, d0_wrA) ||
                 same_reg(d1_wrA_en, d1_wrA, d0_wrB_en, d0_wrB) ||
                 same_reg(d1_wrB_en, d1_wrB, d0_wrA_en, d0_wrA) ||
                 same_reg(d1_wrB_en, d1_wrB, d0_wrB_en, d0_wrB);

  // Single data-memory port.
  assign mem01 = d0_mem && d1_mem;

  assign issue0 = !reset && !flush && !halt && slot0_occ && !hz0 &&
                  (!d0_serial || pipe_empty);

  // Strictly in order: slot1 rides only with slot0, and never next to a
  // serializing instruction in either slot.
  assign issue1 = issue0 && slot1_occ && !d0_serial && !d1_serial &&
                  !raw01 && !waw01 && !mem01 && !hz1;

  assign issue_count = {issue1, issue0 && !issue1};

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q + QAW'(issue_count);
    tail_d  = fetch_acc ? (tail_q + QAW'(2)) : tail_q;
    count_d = count_q + (fetch_acc ? TWO_CNT : '0) - (QAW+1)'(issue_count);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // A slot that does not issue becomes a bubble with invalid tags.  The
  // execute stage keeps advancing through a flush; in-flight work completes.
  always_comb begin
    x0_valid_d = issue0;
    x1_valid_d = issue1;
    x0_inst_d  = issue0 ? d0_inst : 32'h0;
    x1_inst_d  = issue1 ? d1_inst : 32'h0;
    xtag_d[0]  = {issue0 && d0_wrA_en, d0_wrA & {5{issue0}}};
    xtag_d[1]  = {issue0 && d0_wrB_en, d0_wrB & {5{issue0}}};
    xtag_d[2]  = {issue1 && d1_wrA_en, d1_wrA & {5{issue1}}};
    xtag_d[3]  = {issue1 && d1_wrB_en, d1_wrB & {5{issue1}}};
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      x0_valid_q <= 1'b0;
      x1_valid_q <= 1'b0;
      x0_inst_q  <= 32'h0;
      x1_inst_q  <= 32'h0;
      xtag_q     <= '0;
      wbtag_q    <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      x0_valid_q <= x0_valid_d;
      x1_valid_q <= x1_valid_d;
      x0_inst_q  <= x0_inst_d;
      x1_inst_q  <= x1_inst_d;
      xtag_q     <= xtag_d;
      // WB tags are dropped after one cycle, when the register write lands.
      wbtag_q    <= xtag_q;
    end
  end

  // Queue storage needs no reset; occupancy decides what is visible.
  // fetch_acc is already low during reset and flush.
  always_ff @(posedge clk) begin
    if (fetch_acc) begin
      queue_q[tail_q]  <= fetch_data[31:0];
      queue_q[tail_p1] <= fetch_data[63:32];
    end
  end

  assign x0_valid = x0_valid_q;
  assign x1_valid = x1_valid_q;
  assign x0_inst  = x0_inst_q;
  assign x1_inst  = x1_inst_q;
  assign q_count  = count_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler.  The bench also plays the external
// decoder using a small private instruction encoding:
//   [31:28] op, [24:20] rd, [19:15] ra, [14:10] rb, [9:0] tag (free id)
//   op 1 addi rd,ra,imm   op 2 add rd,ra,rb   op 3 ld rd,(ra)
//   op 4 std rd,(ra)      op 5 ldu rd,(ra)    op 6 sc
// A base register of r0 means "literal zero", so its read enable is off.
module tb_dual_issue_scheduler;

  localparam int QDEPTH = 64;
  localparam int QAW    = 6;

  logic              clk;
  logic              reset;
  logic              fetch_valid;
  logic [63:0]       fetch_data;
  logic              fetch_ready;
  logic              flush;
  logic              halt;
  logic [31:0]       d0_inst, d1_inst;
  logic              x0_valid, x1_valid;
  logic [31:0]       x0_inst, x1_inst;
  logic [1:0]        issue_count;
  logic [QAW:0]      q_count;

  typedef struct packed {
    logic       rdA_en;
    logic       rdB_en;
    logic [4:0] rdA;
    logic [4:0] rdB;
    logic       wrA_en;
    logic       wrB_en;
    logic [4:0] wrA;
    logic [4:0] wrB;
    logic       mem;
    logic       serial;
  } dec_t;

  dec_t dec0, dec1;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- DUT
  dual_issue_scheduler #(.QDEPTH(QDEPTH), .QAW(QAW)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .flush(flush), .halt(halt),
    .d0_inst(d0_inst), .d1_inst(d1_inst),
    .d0_rdA_en(dec0.rdA_en), .d0_rdB_en(dec0.rdB_en),
    .d0_rdA(dec0.rdA), .d0_rdB(dec0.rdB),
    .d0_wrA_en(dec0.wrA_en), .d0_wrB_en(dec0.wrB_en),
    .d0_wrA(dec0.wrA), .d0_wrB(dec0.wrB),
    .d0_mem(dec0.mem), .d0_serial(dec0.serial),
    .d1_rdA_en(dec1.rdA_en), .d1_rdB_en(dec1.rdB_en),
    .d1_rdA(dec1.rdA), .d1_rdB(dec1.rdB),
    .d1_wrA_en(dec1.wrA_en), .d1_wrB_en(dec1.wrB_en),
    .d1_wrA(dec1.wrA), .d1_wrB(dec1.wrB),
    .d1_mem(dec1.mem), .d1_serial(dec1.serial),
    .x0_valid(x0_valid), .x1_valid(x1_valid),
    .x0_inst(x0_inst), .x1_inst(x1_inst),
    .issue_count(issue_count), .q_count(q_count)
  );

  // ---------------------------------------------------------------- decoder model
  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                     input logic [4:0] ra, input logic [4:0] rb,
                                     input logic [9:0] tag);
    return {op, 3'b000, rd, ra, rb, tag};
  endfunction

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic [3:0] op;
    logic [4:0] rd, ra, rb;
    d  = '0;
    op = i[31:28];
    rd = i[24:20];
    ra = i[19:15];
    rb = i[14:10];
    d.rdA = ra;
    d.rdB = rb;
    d.wrA = rd;
    d.wrB = ra;
    case (op)
      4'd1: begin d.wrA_en = 1'b1; d.rdA_en = (ra != 0); end
      4'd2: begin d.wrA_en = 1'b1; d.rdA_en = 1'b1; d.rdB_en = 1'b1; end
      4'd3: begin d.wrA_en = 1'b1; d.rdA_en = (ra != 0); d.mem = 1'b1; end
      4'd4: begin d.rdA_en = (ra != 0); d.rdB_en = 1'b1; d.rdB = rd; d.mem = 1'b1; end
      4'd5: begin d.wrA_en = 1'b1; d.wrB_en = 1'b1; d.rdA_en = 1'b1; d.mem = 1'b1; end
      4'd6: d.serial = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

  always_comb dec0 = decode(d0_inst);
  always_comb dec1 = decode(d1_inst);

  // Instruction stream used for the halt/fill/drain run.
  function automatic logic [31:0] seq_inst(input int s);
    if (s == 0)           return mk(4'd6, 5'd0, 5'd0, 5'd0, 10'd0);
    else if (s % 2 == 0)  return mk(4'd1, 5'd11, 5'd0, 5'd0, 10'(s));
    else                  return mk(4'd1, 5'd12, 5'd0, 5'd0, 10'(s));
  endfunction

  // ---------------------------------------------------------------- checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic win();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [31:0] a0, a1, b0, b1, c0, c1, e0, e1, g0, g1, k0, k1, sc_i, f0, f1;
  int qe, nseq, n_iss;

  initial begin
    a0 = mk(4'd1, 5'd3,  5'd0, 5'd0, 10'd1);    // addi r3,r0,1
    a1 = mk(4'd1, 5'd4,  5'd0, 5'd0, 10'd2);    // addi r4,r0,2
    b0 = mk(4'd1, 5'd3,  5'd0, 5'd0, 10'd5);    // addi r3,r0,5
    b1 = mk(4'd2, 5'd5,  5'd3, 5'd3, 10'd0);    // add  r5,r3,r3
    c0 = mk(4'd3, 5'd6,  5'd1, 5'd0, 10'd0);    // ld   r6,0(r1)
    c1 = mk(4'd4, 5'd7,  5'd1, 5'd0, 10'd8);    // std  r7,8(r1)
    e0 = mk(4'd5, 5'd8,  5'd9, 5'd0, 10'd8);    // ldu  r8,8(r9)
    e1 = mk(4'd1, 5'd10, 5'd9, 5'd0, 10'd4);    // addi r10,r9,4
    sc_i = mk(4'd6, 5'd0, 5'd0, 5'd0, 10'd0);   // sc
    f0 = mk(4'd1, 5'd13, 5'd0, 5'd0, 10'd7);    // addi r13,r0,7
    f1 = mk(4'd1, 5'd14, 5'd0, 5'd0, 10'd8);    // addi r14,r0,8
    g0 = mk(4'd1, 5'd21, 5'd0, 5'd0, 10'd1);    // addi r21,r0,1
    g1 = mk(4'd1, 5'd22, 5'd0, 5'd0, 10'd2);    // addi r22,r0,2
    k0 = mk(4'd2, 5'd5,  5'd3, 5'd3, 10'd0);    // add  r5,r3,r3
    k1 = mk(4'd1, 5'd23, 5'd0, 5'd0, 10'd3);    // addi r23,r0,3

    reset = 1'b1; fetch_valid = 1'b0; fetch_data = '0; flush = 1'b0; halt = 1'b0;

    // Reset state
    win(); #1;
    chk("rst_fetch_ready", fetch_ready, 0);
    win(); #1;
    chk("rst_q_count", q_count, 0);
    chk("rst_x0_valid", x0_valid, 0);
    chk("rst_x1_valid", x1_valid, 0);
    chk("rst_x0_inst", x0_inst, 0);
    chk("rst_d0_inst", d0_inst, 0);
    win(); reset = 1'b0; #1;
    chk("post_rst_fetch_ready", fetch_ready, 1);
    chk("post_rst_issue", issue_count, 0);

    // Independent pairs stream through two at a time
    win(); fetch_valid = 1'b1; fetch_data = {a1, a0}; #1;
    chk("fill_issue", issue_count, 0);
    win(); #1;
    chk("pair_issue", issue_count, 2);
    chk("pair_q", q_count, 2);
    chk("pair_d0", d0_inst, a0);
    chk("pair_d1", d1_inst, a1);
    win(); #1;
    chk("pair_issue2", issue_count, 2);
    chk("pair_x0", x0_inst, a0);
    chk("pair_x1", x1_inst, a1);
    chk("pair_x0_valid", x0_valid, 1);
    win(); fetch_valid = 1'b0; #1;
    chk("pair_issue3", issue_count, 2);
    win(); #1;
    chk("pair_drained_q", q_count, 0);
    chk("pair_drained_issue", issue_count, 0);
    chk("pair_last_x1", x1_inst, a1);
    win(); win(); win();

    // RAW across the pair, then through X and WB
    win(); fetch_valid = 1'b1; fetch_data = {b1, b0}; #1;
    chk("raw_fill", issue_count, 0);
    win(); fetch_valid = 1'b0; #1;
    chk("raw_pair_issue", issue_count, 1);
    win(); #1;
    chk("raw_x_stall", issue_count, 0);
    chk("raw_x0", x0_inst, b0);
    chk("raw_x1_valid", x1_valid, 0);
    chk("raw_q", q_count, 1);
    chk("raw_d1_empty", d1_inst, 0);
    win(); #1;
    chk("raw_wb_stall", issue_count, 0);
    win(); #1;
    chk("raw_release", issue_count, 1);
    win(); #1;
    chk("raw_x0_after", x0_inst, b1);
    chk("raw_q_after", q_count, 0);

    // Memory port conflict and ldu base-register write
    win(); fetch_valid = 1'b1; fetch_data = {c1, c0}; #1;
    chk("mem_fill", issue_count, 0);
    win(); fetch_data = {e1, e0}; #1;
    chk("mem_conflict", issue_count, 1);
    win(); fetch_valid = 1'b0; #1;
    chk("mem_conflict2", issue_count, 1);
    chk("mem_q", q_count, 3);
    win(); #1;
    chk("ldu_pair_block", issue_count, 1);
    chk("ldu_d1", d1_inst, e1);
    win(); #1;
    chk("ldu_wrb_x_stall", issue_count, 0);
    win(); #1;
    chk("ldu_wrb_wb_stall", issue_count, 0);
    win(); #1;
    chk("ldu_wrb_release", issue_count, 1);
    win(); win(); win();

    // Halt with continuous fetch: fill to 64, no overwrite
    for (int h = 0; h < 40; h++) begin
      win(); halt = 1'b1; fetch_valid = 1'b1;
      fetch_data = {seq_inst(2*h+1), seq_inst(2*h)}; #1;
      chk("halt_issue", issue_count, 0);
      if (h == 31) begin
        chk("halt_q62", q_count, 62);
        chk("halt_ready62", fetch_ready, 1);
      end
      if (h >= 32) begin
        chk("halt_q64", q_count, 64);
        chk("halt_ready64", fetch_ready, 0);
      end
    end
    win(); halt = 1'b0; fetch_valid = 1'b0; #1;
    chk("full_d0_intact", d0_inst, seq_inst(0));
    chk("full_d1_intact", d1_inst, seq_inst(1));
    chk("full_sc_alone", issue_count, 1);
    win(); #1;
    chk("q63", q_count, 63);
    chk("ready63", fetch_ready, 0);
    chk("after_sc_issue", issue_count, 2);
    chk("sc_in_x0", x0_inst, seq_inst(0));
    chk("sc_x1_bubble", x1_valid, 0);

    // Drain in order across the pointer wrap
    nseq = 3;
    qe   = 61;
    for (int it = 0; it < 40 && qe > 0; it++) begin
      win(); #1;
      n_iss = (qe >= 2) ? 2 : 1;
      chk("drain_issue", issue_count, n_iss);
      chk("drain_d0", d0_inst, seq_inst(nseq));
      if (qe >= 2) chk("drain_d1", d1_inst, seq_inst(nseq + 1));
      else         chk("drain_d1_empty", d1_inst, 0);
      chk("drain_x0", x0_inst, seq_inst(nseq - 2));
      chk("drain_x1", x1_inst, seq_inst(nseq - 1));
      nseq += n_iss;
      qe   -= n_iss;
    end
    win(); #1;
    chk("drain_q_end", q_count, 0);
    chk("drain_last_x0", x0_inst, seq_inst(63));
    chk("drain_last_x1_valid", x1_valid, 0);
    win(); win();

    // sc behind addi r3: waits for empty pipe, issues alone
    win(); fetch_valid = 1'b1; fetch_data = {sc_i, a0}; #1;
    chk("sc_fill", issue_count, 0);
    win(); fetch_data = {f1, f0}; #1;
    chk("sc_blocks_slot1", issue_count, 1);
    win(); fetch_valid = 1'b0; #1;
    chk("sc_wait_x", issue_count, 0);
    chk("sc_wait_q", q_count, 3);
    win(); #1;
    chk("sc_wait_wb", issue_count, 0);
    chk("sc_wait_x0_valid", x0_valid, 0);
    win(); #1;
    chk("sc_issue_alone", issue_count, 1);
    chk("sc_d0", d0_inst, sc_i);
    win(); #1;
    chk("after_sc_pair", issue_count, 2);
    chk("sc_x0", x0_inst, sc_i);
    chk("sc_x1_empty", x1_valid, 0);
    win(); #1;
    chk("sc_q_end", q_count, 0);

    // Flush with 10 queued and a fetch pending
    for (int l = 0; l < 5; l++) begin
      win(); halt = 1'b1; fetch_valid = 1'b1;
      fetch_data = (l == 0) ? {a1, a0} : {g1, g0}; #1;
      chk("flush_fill_issue", issue_count, 0);
    end
    win(); halt = 1'b0; #1;
    chk("flush_pre_q", q_count, 10);
    chk("flush_pre_issue", issue_count, 2);
    chk("flush_pre_d0", d0_inst, a0);
    win(); flush = 1'b1; #1;
    chk("flush_ready", fetch_ready, 0);
    chk("flush_no_issue", issue_count, 0);
    chk("flush_x0_inflight", x0_inst, a0);
    win(); flush = 1'b0; fetch_data = {k1, k0}; #1;
    chk("flush_q0", q_count, 0);
    chk("flush_d0_empty", d0_inst, 0);
    chk("flush_x0_bubble", x0_valid, 0);
    chk("flush_refill_issue", issue_count, 0);
    win(); fetch_valid = 1'b0; #1;
    chk("flush_tags_retired", issue_count, 2);
    chk("flush_refill_q", q_count, 2);
    win(); #1;
    chk("flush_x0_after", x0_inst, k0);
    chk("flush_x1_after", x1_inst, k1);
    chk("flush_q_end", q_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
